pcie_flow_ctrl_init_rx: RTL

//  Receive side of DL flow-control initialisation. Parses the inbound DLLP AXI stream, checks the CRC16,
//  and records the link partner's InitFC1 P/NP/Cpl header and data credits for its VC.

---
 rtl/pcie_flow_ctrl_init_rx.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pcie_flow_ctrl_init_rx.sv
// pcie_flow_ctrl_init_rx: DLLP receive parser with CRC16 check, records the link partner's InitFC credits for one VC
module pcie_flow_ctrl_init_rx #(
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = DATA_WIDTH/8,
   parameter int USER_WIDTH = 3,
   parameter int VC_ID      = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_flow_control_i,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_i,
   input  logic                  s_axis_tvalid_i,
   input  logic                  s_axis_tlast_i,
   input  logic [USER_WIDTH-1:0] s_axis_tuser_i,
   output logic                  s_axis_tready_o,
   output logic [7:0]            hdr_fc_p_o,
   output logic [7:0]            hdr_fc_np_o,
   output logic [7:0]            hdr_fc_cpl_o,
   output logic [11:0]           data_fc_p_o,
   output logic [11:0]           data_fc_np_o,
   output logic [11:0]           data_fc_cpl_o,
   output logic                  fc1_values_stored_o,
   output logic                  fc2_values_stored_o,
   output logic                  crc_err_o
);
   typedef enum logic [1:0] {RX_BODY, RX_CRC, RX_DROP} rx_t;
   typedef enum logic [1:0] {ST_IDLE, ST_FC1, ST_FC2, ST_COMPLETE} st_t;
   rx_t         rx_q;
   st_t         st_q;
   logic [31:0] body_q;
   logic        ok_q, err_q, fc1_q, fc2_q;
   logic [2:0]  seen_q, seen_d;
   logic [7:0]  hdr_p_q, hdr_np_q, hdr_cpl_q, hdr;
   logic [11:0] data_p_q, data_np_q, data_cpl_q, data;
   logic [7:0]  typ;
   logic        fc_ok, p1, np1, cpl1, fc2_evt, body_good, crc_good;
   logic        unused;
   // Bits fed LSB-first from byte 0; complemented result is bit-reversed per byte on the wire
   function automatic logic [15:0] dllp_crc(input logic [31:0] d);
      logic [15:0] c, r;
      c = 16'hFFFF;
      for (int i = 0; i < 32; i++) c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h100B : 16'h0000);
      for (int i = 0; i < 8; i++) begin
         r[i]     = ~c[15-i];
         r[8+i]   = ~c[7-i];
      end
      return r;
   endfunction
   assign unused     = ^s_axis_tuser_i[USER_WIDTH-1:1];
   assign s_axis_tready_o = 1'b1;
   assign body_good  = s_axis_tkeep_i == 4'hF && !s_axis_tlast_i && !s_axis_tuser_i[0];
   assign crc_good   = s_axis_tdata_i[15:0] == dllp_crc(body_q) && s_axis_tkeep_i == 4'h3 &&
                       s_axis_tlast_i && !s_axis_tuser_i[0];
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_q   <= RX_BODY;
         body_q <= '0;
         ok_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         ok_q  <= 1'b0;
         err_q <= 1'b0;
         if (s_axis_tvalid_i)
            case (rx_q)
               RX_BODY: begin
                  body_q <= s_axis_tdata_i;
                  if (body_good) rx_q <= RX_CRC;
                  else begin
                     err_q <= 1'b1;
                     rx_q  <= s_axis_tlast_i ? RX_BODY : RX_DROP;
                  end
               end
               RX_CRC: begin
                  ok_q  <= crc_good;
                  err_q <= !crc_good;
                  rx_q  <= s_axis_tlast_i ? RX_BODY : RX_DROP;
               end
               default: rx_q <= s_axis_tlast_i ? RX_BODY : RX_DROP;
            endcase
      end
   end
   assign typ     = body_q[7:0];
   assign hdr     = {body_q[13:8], body_q[23:22]};
   assign data    = {body_q[19:16], body_q[31:24]};
   assign fc_ok   = ok_q && typ[2:0] == 3'(VC_ID) && !typ[3];
   assign p1      = fc_ok && typ[7:4] == 4'h4;
   assign np1     = fc_ok && typ[7:4] == 4'h5;
   assign cpl1    = fc_ok && typ[7:4] == 4'h6;
   assign fc2_evt = fc_ok && typ[7:4] inside {4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE};
   assign seen_d  = seen_q | {cpl1, np1, p1};
   always_ff @(posedge clk_i) begin
      if (rst_i || !start_flow_control_i) begin
         st_q       <= ST_IDLE;
         seen_q     <= '0;
         fc1_q      <= 1'b0;
         fc2_q      <= 1'b0;
         hdr_p_q    <= '0;
         hdr_np_q   <= '0;
         hdr_cpl_q  <= '0;
         data_p_q   <= '0;
         data_np_q  <= '0;
         data_cpl_q <= '0;
      end else
         case (st_q)
            ST_IDLE: st_q <= ST_FC1;
            ST_FC1: begin
               if (p1) begin
                  hdr_p_q  <= hdr;
                  data_p_q <= data;
               end
               if (np1) begin
                  hdr_np_q  <= hdr;
                  data_np_q <= data;
               end
               if (cpl1) begin
                  hdr_cpl_q  <= hdr;
                  data_cpl_q <= data;
               end
               seen_q <= seen_d;
               if (&seen_d) begin
                  fc1_q <= 1'b1;
                  st_q  <= ST_FC2;
               end
            end
            ST_FC2:
               if (fc2_evt) begin
                  fc2_q <= 1'b1;
                  st_q  <= ST_COMPLETE;
               end
            default: st_q <= st_q;
         endcase
   end
   assign hdr_fc_p_o          = hdr_p_q;
   assign hdr_fc_np_o         = hdr_np_q;
   assign hdr_fc_cpl_o        = hdr_cpl_q;
   assign data_fc_p_o         = data_p_q;
   assign data_fc_np_o        = data_np_q;
   assign data_fc_cpl_o       = data_cpl_q;
   assign fc1_values_stored_o = fc1_q;
   assign fc2_values_stored_o = fc2_q;
   assign crc_err_o           = err_q;
endmodule
